// File: rtl/polaris_uart_pkg.sv
// Shared definitions for the Polaris CSR UART transmitter: CSR offsets,
// STATUS bit layout, transmit FSM states and the STATUS word packer.
package polaris_uart_pkg;

  localparam logic [11:0] UART_TXDATA  = 12'd0;
  localparam logic [11:0] UART_STATUS  = 12'd1;
  localparam logic [11:0] UART_DIVISOR = 12'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_IE      = 4;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  function automatic logic [63:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic ie, input logic [6:0] count);
    logic [63:0] w;
    w = '0;
    w[ST_FULL]           = full;
    w[ST_EMPTY]          = empty;
    w[ST_BUSY]           = busy;
    w[ST_OVF]            = ovf;
    w[ST_IE]             = ie;
    w[ST_CNT_LSB +: 7]   = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (wptr_q == rptr_q);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 serial transmitter with a byte FIFO and programmable bit rate.
// Define POLARIS_UART_IRQ_EN to add irq_o and a writable IE bit in STATUS.
module csr_uart_tx
  import polaris_uart_pkg::*;
#(
  parameter logic [11:0] BASE_ADR   = 12'h780,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [11:0] cadr_i,
  input  logic        coe_i,
  input  logic        cwe_i,
  input  logic [63:0] cdat_i,
  output logic [63:0] cdat_o,
  output logic        cvalid_o,
  output logic        txd_o
`ifdef POLARIS_UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    div_q, div_d, reload_q, reload_d, timer_q, timer_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           txd_q, txd_d, ovf_q, ovf_d;
  logic [11:0]    offset;
  logic           hit, wr_status, wr_divisor, bit_done, ie;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  logic [63:0]    rdata;
  logic           unused_cdat;

  assign unused_cdat = ^cdat_i[63:16];

  // Unsigned wrap makes addresses below BASE_ADR fall out of range too.
  assign offset     = cadr_i - BASE_ADR;
  assign hit        = (offset <= UART_DIVISOR);
  assign cvalid_o   = (coe_i | cwe_i) & hit;
  assign fifo_push  = cwe_i && hit && (offset == UART_TXDATA);
  assign wr_status  = cwe_i && hit && (offset == UART_STATUS);
  assign wr_divisor = cwe_i && hit && (offset == UART_DIVISOR);
  assign bit_done   = (timer_q == 16'd0);
  assign txd_o      = txd_q;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (cdat_i[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rdata = status_word(fifo_full, fifo_empty, state_q != IDLE, ovf_q, ie, 7'(fifo_count));
    if (offset == UART_DIVISOR) rdata = {48'd0, div_q};
    cdat_o = (cvalid_o && coe_i) ? rdata : 64'd0;
  end

  // A dropped push sets overflow after the clear so the set wins.
  always_comb begin
    div_d = wr_divisor ? cdat_i[15:0] : div_q;
    ovf_d = ovf_q;
    if (wr_status && cdat_i[ST_OVF]) ovf_d = 1'b0;
    if (fifo_push && fifo_full)      ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    reload_d  = reload_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          reload_d = div_q;
          timer_d  = div_q;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d   = reload_q;
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end else timer_d = timer_q - 16'd1;
      end
      DATA: begin
        if (bit_done) begin
          timer_d = reload_q;
          if (bit_cnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            txd_d     = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else timer_d = timer_q - 16'd1;
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            reload_d = div_q;
            timer_d  = div_q;
            txd_d    = 1'b0;
            state_d  = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else timer_d = timer_q - 16'd1;
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      div_q     <= DIV_RESET;
      reload_q  <= 16'd0;
      timer_q   <= 16'd0;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      reload_q  <= reload_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef POLARIS_UART_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  assign ie    = ie_q;
  assign irq_o = irq_q;

  always_comb begin
    ie_d  = wr_status ? cdat_i[ST_IE] : ie_q;
    irq_d = ie_q && fifo_empty && (state_q == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end
`else
  assign ie = 1'b0;
`endif

endmodule

// File: tb/tb_csr_uart_tx.sv
// Self-checking bench for csr_uart_tx: txd_o is logged once per cycle and
// decoded into frames that are compared against a byte-level model.
`timescale 1ns/100ps
module tb_csr_uart_tx;
  localparam logic [11:0] BASE  = 12'h780;
  localparam logic [11:0] A_TX  = BASE;
  localparam logic [11:0] A_ST  = BASE + 12'd1;
  localparam logic [11:0] A_DIV = BASE + 12'd2;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [11:0] cadr_i = '0;
  logic        coe_i = 1'b0;
  logic        cwe_i = 1'b0;
  logic [63:0] cdat_i = '0;
  logic [63:0] cdat_o;
  logic        cvalid_o;
  logic        txd_o;
`ifdef POLARIS_UART_IRQ_EN
  logic        irq_o;
`endif

  always #5 clk = ~clk;

  csr_uart_tx #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .cadr_i   (cadr_i),
    .coe_i    (coe_i),
    .cwe_i    (cwe_i),
    .cdat_i   (cdat_i),
    .cdat_o   (cdat_o),
    .cvalid_o (cvalid_o),
    .txd_o    (txd_o)
`ifdef POLARIS_UART_IRQ_EN
    ,
    .irq_o    (irq_o)
`endif
  );

  int         errors = 0;
  int         checks = 0;
  logic       txd_log[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_fifo[$];
  bit         m_busy = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_ie = 1'b0;

  always @(negedge clk) txd_log.push_back(txd_o);

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] adr, input logic [63:0] data);
    cadr_i = adr;
    cdat_i = data;
    cwe_i  = 1'b1;
    @(posedge clk);
    #1;
    cwe_i  = 1'b0;
    cdat_i = '0;
  endtask

  task automatic csr_rd(input logic [11:0] adr, output logic [63:0] data);
    cadr_i = adr;
    coe_i  = 1'b1;
    #0.2;
    data   = cdat_o;
    coe_i  = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Occupancy model: a push is refused when DEPTH bytes are queued before the
  // edge; an idle transmitter takes the head byte one edge after it arrives.
  task automatic model_write(input logic [7:0] b);
    bit pop_now;
    pop_now = !m_busy && (m_fifo.size() > 0);
    if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
    else begin
      m_fifo.push_back(b);
      exp_q.push_back(b);
    end
    if (pop_now) begin
      void'(m_fifo.pop_front());
      m_busy = 1'b1;
    end
  endtask

  task automatic model_settle();
    if (!m_busy && m_fifo.size() > 0) begin
      void'(m_fifo.pop_front());
      m_busy = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    m_ie   = 1'b0;
  endtask

  function automatic logic [63:0] model_status();
    logic [63:0] w;
    w        = '0;
    w[0]     = (m_fifo.size() == DEPTH);
    w[1]     = (m_fifo.size() == 0);
    w[2]     = m_busy;
    w[3]     = m_ovf;
    w[4]     = m_ie;
    w[14:8]  = 7'(m_fifo.size());
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    csr_wr(A_TX, {56'd0, b});
    model_write(b);
  endtask

  // ---------------- log analysis ----------------
  function automatic int find_start(input int from);
    for (int i = from; i < txd_log.size(); i++)
      if (txd_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int count_low(input int from);
    int n = 0;
    for (int i = from; i < txd_log.size(); i++)
      if (txd_log[i] !== 1'b1) n++;
    return n;
  endfunction

  task automatic decode_frame(input int start, input int d,
                              output logic [9:0] bits, output bit stable);
    logic v;
    stable = 1'b1;
    bits   = 'x;
    for (int slot = 0; slot < 10; slot++)
      for (int c = 0; c <= d; c++) begin
        int idx = start + slot * (d + 1) + c;
        v = (idx >= 0 && idx < txd_log.size()) ? txd_log[idx] : 1'bx;
        if (idx < 0 || idx >= txd_log.size()) stable = 1'b0;
        if (c == 0) bits[slot] = v;
        else if (v !== bits[slot]) stable = 1'b0;
      end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    logic [63:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      csr_rd(A_ST, s);
      if (s[2] == 1'b0 && s[1] == 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    m_fifo.delete();
    m_busy = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [63:0] s;
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
    model_reset();
    checks++;
    if (txd_o !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd_o); end
    csr_rd(A_ST, s);
    checks++;
    if (s !== 64'h2) begin errors++; $display("FAIL reset_status: got %h want %h", s, 64'h2); end
    csr_rd(A_DIV, s);
    checks++;
    if (s !== 64'd433) begin errors++; $display("FAIL reset_divisor: got %0d want 433", s); end
    csr_rd(A_TX, s);
    checks++;
    if (s !== 64'h2) begin errors++; $display("FAIL reset_txdata_read: got %h want 2", s); end
`ifdef POLARIS_UART_IRQ_EN
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
`endif
  endtask

  task automatic test_decode();
    logic [63:0] s;
    cadr_i = BASE + 12'd3; coe_i = 1'b1; #0.2;
    checks++;
    if (cvalid_o !== 1'b0 || cdat_o !== 64'd0) begin
      errors++; $display("FAIL decode_above: cvalid=%b cdat=%h want 0/0", cvalid_o, cdat_o);
    end
    cadr_i = BASE - 12'd1; #0.2;
    checks++;
    if (cvalid_o !== 1'b0 || cdat_o !== 64'd0) begin
      errors++; $display("FAIL decode_below: cvalid=%b cdat=%h want 0/0", cvalid_o, cdat_o);
    end
    cadr_i = A_DIV; coe_i = 1'b0; #0.2;
    checks++;
    if (cvalid_o !== 1'b0 || cdat_o !== 64'd0) begin
      errors++; $display("FAIL decode_nostrobe: cvalid=%b cdat=%h want 0/0", cvalid_o, cdat_o);
    end
    cdat_i = 64'hFFFF_FFFF_0000_0003; cwe_i = 1'b1; #0.2;
    checks++;
    if (cvalid_o !== 1'b1 || cdat_o !== 64'd0) begin
      errors++; $display("FAIL decode_write_only: cvalid=%b cdat=%h want 1/0", cvalid_o, cdat_o);
    end
    @(posedge clk); #1;
    cwe_i = 1'b0; cdat_i = '0;
    csr_rd(A_DIV, s);
    checks++;
    if (s !== 64'd3) begin errors++; $display("FAIL divisor_upper_ignored: got %h want 3", s); end
  endtask

  task automatic test_single_byte();
    logic [63:0] s;
    logic [9:0]  bits, want;
    bit          st;
    int          start, busy_bad;
    csr_wr(A_DIV, 64'd3);
    txd_log.delete();
    send_byte(8'h55);
    csr_rd(A_ST, s);
    checks++;
    if (s !== model_status()) begin
      errors++; $display("FAIL single_status_pushed: got %h want %h", s, model_status());
    end
    model_settle();
    busy_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      csr_rd(A_ST, s);
      if (s[2] !== 1'b1) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL single_busy: %0d idle cycles want 0", busy_bad); end
    tick(1);
    csr_rd(A_ST, s);
    checks++;
    if (s !== 64'h2) begin errors++; $display("FAIL single_status_done: got %h want 2", s); end
    tick(4);
    start = find_start(0);
    checks++;
    if (start != 2) begin errors++; $display("FAIL single_latency: start index %0d want 2", start); end
    decode_frame(start, 3, bits, st);
    want = {1'b1, exp_q.pop_front(), 1'b0};
    checks++;
    if (bits !== want || !st) begin
      errors++; $display("FAIL single_frame: bits=%b stable=%0d want %b", bits, st, want);
    end
    checks++;
    if (count_low(start + 40) != 0) begin
      errors++; $display("FAIL single_tail: %0d low samples want 0", count_low(start + 40));
    end
    m_busy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits, want;
    bit         st, ok;
    int         pos;
    csr_wr(A_DIV, 64'd0);
    txd_log.delete();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    model_settle();
    tick(30);
    pos = find_start(0);
    checks++;
    if (pos != 2) begin errors++; $display("FAIL b2b_latency: start index %0d want 2", pos); end
    for (int f = 0; f < 2; f++) begin
      decode_frame(pos, 0, bits, st);
      want = {1'b1, exp_q.pop_front(), 1'b0};
      checks++;
      if (bits !== want || !st) begin
        errors++; $display("FAIL b2b_frame%0d: bits=%b stable=%0d want %b", f, bits, st, want);
      end
      pos += 10;
    end
    checks++;
    if (count_low(pos) != 0) begin errors++; $display("FAIL b2b_tail: extra low samples %0d", count_low(pos)); end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_idle: busy after budget"); end
  endtask

  task automatic test_divisor_midframe();
    logic [63:0] s;
    logic [9:0]  bits, want;
    bit          st, ok;
    int          pos;
    csr_wr(A_DIV, 64'd2);
    txd_log.delete();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    model_settle();
    tick(5);
    csr_wr(A_DIV, 64'd5);
    tick(100);
    pos = 2;
    decode_frame(pos, 2, bits, st);
    want = {1'b1, exp_q.pop_front(), 1'b0};
    checks++;
    if (bits !== want || !st) begin
      errors++; $display("FAIL middiv_frame0: bits=%b stable=%0d want %b", bits, st, want);
    end
    pos += 30;
    decode_frame(pos, 5, bits, st);
    want = {1'b1, exp_q.pop_front(), 1'b0};
    checks++;
    if (bits !== want || !st) begin
      errors++; $display("FAIL middiv_frame1: bits=%b stable=%0d want %b", bits, st, want);
    end
    csr_rd(A_DIV, s);
    checks++;
    if (s !== 64'd5) begin errors++; $display("FAIL middiv_readback: got %0d want 5", s); end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL middiv_idle: busy after budget"); end
  endtask

  task automatic test_overflow();
    logic [63:0] s;
    logic [9:0]  bits, want;
    bit          st, ok;
    int          pos;
    csr_wr(A_DIV, 64'd100);
    txd_log.delete();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
    csr_rd(A_ST, s);
    checks++;
    if (s !== model_status() || s[0] !== 1'b1 || s[3] !== 1'b1 || s[14:8] !== 7'd8) begin
      errors++; $display("FAIL ovf_status: got %h want %h", s, model_status());
    end
    csr_wr(A_ST, 64'h8);
    m_ovf = 1'b0;
    csr_rd(A_ST, s);
    checks++;
    if (s !== model_status() || s[3] !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %h want %h", s, model_status());
    end
    tick(9 * 1010 + 20);
    pos = find_start(0);
    checks++;
    if (pos != 2) begin errors++; $display("FAIL ovf_latency: start index %0d want 2", pos); end
    for (int f = 0; f < 9; f++) begin
      decode_frame(pos, 100, bits, st);
      want = {1'b1, exp_q.pop_front(), 1'b0};
      checks++;
      if (bits !== want || !st) begin
        errors++; $display("FAIL ovf_frame%0d: bits=%b stable=%0d want %b", f, bits, st, want);
      end
      pos += 1010;
    end
    checks++;
    if (count_low(pos) != 0) begin errors++; $display("FAIL ovf_tenth_frame: low samples %0d want 0", count_low(pos)); end
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_idle: busy after budget"); end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] s;
    csr_wr(A_DIV, 64'd3);
    txd_log.delete();
    send_byte(8'hFF);
    send_byte(8'h00);
    tick(16);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    model_reset();
    checks++;
    if (txd_o !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd_o); end
    csr_rd(A_ST, s);
    checks++;
    if (s !== 64'h2) begin errors++; $display("FAIL rstmid_status: got %h want 2", s); end
    csr_rd(A_DIV, s);
    checks++;
    if (s !== 64'd433) begin errors++; $display("FAIL rstmid_divisor: got %0d want 433", s); end
    txd_log.delete();
    tick(100);
    checks++;
    if (count_low(0) != 0) begin errors++; $display("FAIL rstmid_no_frames: low samples %0d want 0", count_low(0)); end
  endtask

  task automatic test_ie();
    logic [63:0] s;
    bit          ok;
`ifdef POLARIS_UART_IRQ_EN
    int          early;
    csr_wr(A_DIV, 64'd0);
    csr_wr(A_ST, 64'h10);
    m_ie = 1'b1;
    tick(1);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq_o); end
    csr_rd(A_ST, s);
    checks++;
    if (s !== model_status()) begin errors++; $display("FAIL irq_ie_read: got %h want %h", s, model_status()); end
    send_byte(8'($urandom_range(0, 255)));
    model_settle();
    early = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      if (irq_o !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL irq_low_during_frame: %0d high cycles want 0", early); end
    tick(1);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_after_stop: got %b want 1", irq_o); end
    csr_wr(A_ST, 64'h0);
    m_ie = 1'b0;
    exp_q.delete();
`else
    csr_wr(A_ST, 64'h10);
    csr_rd(A_ST, s);
    checks++;
    if (s[4] !== 1'b0 || s !== model_status()) begin
      errors++; $display("FAIL ie_disabled: got %h want %h", s, model_status());
    end
`endif
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ie_idle: busy after budget"); end
  endtask

  task automatic test_random();
    logic [9:0] bits, want;
    bit         st, ok;
    int         d, n, pos;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 3);
      n = $urandom_range(1, DEPTH + 1);
      csr_wr(A_DIV, 64'(d));
      txd_log.delete();
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
      model_settle();
      tick(n * 10 * (d + 1) + 20);
      pos = 2;
      for (int f = 0; f < n; f++) begin
        decode_frame(pos, d, bits, st);
        want = {1'b1, exp_q.pop_front(), 1'b0};
        checks++;
        if (bits !== want || !st) begin
          errors++; $display("FAIL rand%0d_frame%0d: bits=%b stable=%0d want %b (div=%0d)", it, f, bits, st, want, d);
        end
        pos += 10 * (d + 1);
      end
      checks++;
      if (count_low(pos) != 0) begin errors++; $display("FAIL rand%0d_tail: low samples %0d", it, count_low(pos)); end
      wait_idle(50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand%0d_idle: busy after budget", it); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single_byte();
    test_back_to_back();
    test_divisor_midframe();
    test_overflow();
    test_reset_midframe();
    test_ie();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached before the scenarios completed");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
